// File: rtl/sample_acc.sv
// Run accumulator: sums a fixed-length burst of adder words and tracks the largest one,
// then presents the totals until the consumer takes them.
module sample_acc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [CNTW-1:0]        i_len,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [WIDTH-1:0]       i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WIDTH+CNTW-1:0]  o_out_sum,
    output logic [WIDTH-1:0]       o_out_max,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [WIDTH+CNTW-1:0]   r_acc;
    logic [WIDTH+CNTW-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]        r_max;
    logic [WIDTH-1:0]        w_max_nxt;
    logic [CNTW-1:0]         r_cnt;
    logic [CNTW-1:0]         w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_max   <= w_max_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_max_nxt   = r_max;
        w_cnt_nxt   = r_cnt;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;

        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_acc_nxt = '0;
                    w_max_nxt = '0;
                    w_cnt_nxt = i_len;
                    // A zero-length run has nothing to collect, so report an empty result.
                    w_state_nxt = (i_len != '0) ? StAccum : StDone;
                end
            end
            StAccum: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_acc_nxt = r_acc + {{CNTW{1'b0}}, i_in_data};
                    if (i_in_data > r_max) begin
                        w_max_nxt = i_in_data;
                    end
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == CNTW'(1)) begin
                        w_state_nxt = StDone;
                    end
                end
            end
            StDone: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_out_sum = r_acc;
    assign o_out_max = r_max;

endmodule

// File: tb/tb_sample_acc.sv
// Directed bench for sample_acc: hand-computed totals, gaps, back-pressure and mid-run reset.
module tb_sample_acc;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNTW  = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [CNTW-1:0]       len;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH+CNTW-1:0] out_sum;
    logic [WIDTH-1:0]      out_max;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    sample_acc #(
        .WIDTH(WIDTH),
        .CNTW (CNTW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_len      (len),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_sum  (out_sum),
        .o_out_max  (out_max),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic go(input logic [CNTW-1:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic finish_run();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_max", 64'(out_max), 64'd0);

        // len=3, beats 1,2,3
        go(8'd3);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        beat(32'd1);
        beat(32'd2);
        check("t1_not_done", 64'(out_valid), 64'd0);
        beat(32'd3);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_sum", 64'(out_sum), 64'h6);
        check("t1_max", 64'(out_max), 64'h3);
        check("t1_done_ready", 64'(in_ready), 64'd0);
        finish_run();

        // len=2, two all-ones beats
        go(8'd2);
        beat(32'hFFFF_FFFF);
        beat(32'hFFFF_FFFF);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_sum", 64'(out_sum), 64'h01_FFFF_FFFE);
        check("t2_max", 64'(out_max), 64'hFFFF_FFFF);
        finish_run();

        // len=0: straight to DONE; a beat offered in DONE must not be taken
        go(8'd0);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'h77;
        start    = 1'b1;
        len      = 8'd9;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        check("t3_hold_valid", 64'(out_valid), 64'd1);
        check("t3_sum", 64'(out_sum), 64'd0);
        check("t3_max", 64'(out_max), 64'd0);
        finish_run();

        // len=4 with gaps; start pulsed mid-run must be ignored
        go(8'd4);
        beat(32'h10);
        tick();
        beat(32'h20);
        start = 1'b1;
        len   = 8'd1;
        tick();
        tick();
        start = 1'b0;
        len   = '0;
        check("t4_gap_busy", 64'(busy), 64'd1);
        check("t4_gap_sum", 64'(out_sum), 64'h30);
        beat(32'h30);
        check("t4_not_done", 64'(out_valid), 64'd0);
        tick();
        beat(32'h40);
        for (int i = 0; i < 5; i++) begin
            check("t4_valid", 64'(out_valid), 64'd1);
            check("t4_sum", 64'(out_sum), 64'hA0);
            check("t4_max", 64'(out_max), 64'h40);
            check("t4_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        check("t4_still_valid", 64'(out_valid), 64'd1);
        finish_run();

        // len=4 aborted by reset after 2 beats, then len=1 with 0x5
        go(8'd4);
        beat(32'h9);
        beat(32'hA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_abort_valid", 64'(out_valid), 64'd0);
        check("t5_abort_busy", 64'(busy), 64'd0);
        check("t5_abort_sum", 64'(out_sum), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_valid", 64'(out_valid), 64'd0);
        end
        go(8'd1);
        beat(32'h5);
        check("t5_valid", 64'(out_valid), 64'd1);
        check("t5_sum", 64'(out_sum), 64'h5);
        check("t5_max", 64'(out_max), 64'h5);
        finish_run();

        // len=255, all-ones beats: largest possible total
        go(8'd255);
        for (int i = 0; i < 254; i++) begin
            beat(32'hFFFF_FFFF);
        end
        check("t6_not_done", 64'(out_valid), 64'd0);
        beat(32'hFFFF_FFFF);
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_sum", 64'(out_sum), 64'hFE_FFFF_FF01);
        check("t6_max", 64'(out_max), 64'hFFFF_FFFF);
        finish_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
